// File: rtl/xor4_parity_checker.sv
// Frame-level checker behind a 4-input XOR parity stage: counts per-nibble parity errors
// and folds all data bits into a frame parity. Define ODD_PARITY_EN for odd-parity upstreams.
module xor4_parity_checker #(
    parameter int FRAME_LEN = 8,
    parameter int ERR_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       din,
    input  logic             par_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ERR_W-1:0] err_count,
    output logic             frame_par,
    output logic             frame_ok
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [ERR_W-1:0] err_q;
    logic             fpar_q, ok_q;
    logic             rdy, accept, nib_par, exp_par, mismatch, last;

    assign nib_par = ^din;
`ifdef ODD_PARITY_EN
    assign exp_par = ~nib_par;
`else
    assign exp_par = nib_par;
`endif
    assign mismatch = par_in ^ exp_par;
    assign last     = (cnt_q == CNT_W'(FRAME_LEN - 1));

    // Ready is masked by reset so nothing is taken while the block is held in reset.
    assign in_ready = rst_n & rdy;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        rdy       = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (in_valid) state_d = ACCUM;
            end
            ACCUM: begin
                rdy = 1'b1;
                if (in_valid && last) state_d = REPORT;
            end
            REPORT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // First nibble of a frame overwrites the accumulators instead of folding into them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            err_q  <= '0;
            fpar_q <= 1'b0;
            ok_q   <= 1'b1;
        end else if (accept) begin
            if (state_q == IDLE) begin
                cnt_q  <= CNT_W'(1);
                err_q  <= ERR_W'(mismatch);
                fpar_q <= nib_par;
                ok_q   <= ~mismatch;
            end else begin
                cnt_q  <= cnt_q + CNT_W'(1);
                if (mismatch && err_q != ERR_MAX) err_q <= err_q + ERR_W'(1);
                fpar_q <= fpar_q ^ nib_par;
                ok_q   <= ok_q & ~mismatch;
            end
        end
    end

    assign err_count = err_q;
    assign frame_par = fpar_q;
    assign frame_ok  = ok_q;

endmodule
